// File: rtl/prog_loader_if.sv
// Loader bus: byte-stream input, instruction-memory write port and status.
//
// Byte handshake: the source holds byte_valid=1 and byte_data stable until it
// sees a rising edge with byte_ready=1; exactly one byte moves on each rising
// edge where byte_valid and byte_ready are both 1. byte_valid without
// byte_ready, or byte_ready without byte_valid, moves nothing.
interface prog_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     start;
  logic                     byte_valid;
  logic [7:0]               byte_data;
  logic                     byte_ready;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     core_hold;
  logic                     done;
  logic                     error;
  logic [2:0]               state;     // loader FSM state, for observation

  // Source / supervisor side
  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, core_hold, done, error, state
  );

  // Loader side
  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, core_hold, done, error, state
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a little-endian word count followed by that many
// little-endian 32-bit words over a byte stream and writes them to
// instruction memory at consecutive word addresses, holding the core in reset
// until a load completes.
module prog_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_SIZE      = 10
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    WORD  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic [15:0] MEM_WORDS = 16'(MEM_SIZE);

  state_t                   state_q, state_d;
  logic [15:0]              count_q;
  logic [15:0]              word_idx_q;
  logic [1:0]               byte_idx_q;
  logic [23:0]              word_buf_q;   // lanes 0..2 of the word being assembled
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;

  logic        byte_ready;
  logic        wr_en;
  logic        done;
  logic        error;
  logic        core_hold;
  logic        restart;
  logic        xfer;
  logic [15:0] hdr_count;

  assign xfer      = bus.byte_valid & byte_ready;
  assign hdr_count = {bus.byte_data, count_q[7:0]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and Moore outputs; start is only honoured in IDLE, DONE and ERR
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_hold  = 1'b1;
    restart    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          restart = 1'b1;
          state_d = HDR0;
        end
      end
      HDR0: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) state_d = HDR1;
      end
      HDR1: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) begin
          if (hdr_count == 16'd0)           state_d = DONE;
          else if (hdr_count > MEM_WORDS)   state_d = ERR;
          else                              state_d = WORD;
        end
      end
      WORD: begin
        byte_ready = 1'b1;
        if (bus.byte_valid && byte_idx_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (word_idx_q + 16'd1 == count_q) state_d = DONE;
        else                               state_d = WORD;
      end
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (bus.start) begin
          restart = 1'b1;
          state_d = HDR0;
        end
      end
      ERR: begin
        error = 1'b1;
        if (bus.start) begin
          restart = 1'b1;
          state_d = HDR0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Header capture, byte-lane assembly and write-port registers; the write
  // port only changes on the 4th byte of a word so it holds between writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      if (restart) begin
        word_idx_q <= '0;
        byte_idx_q <= '0;
      end
      if (xfer) begin
        case (state_q)
          HDR0: count_q[7:0]  <= bus.byte_data;
          HDR1: count_q[15:8] <= bus.byte_data;
          WORD: begin
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_buf_q[7:0]   <= bus.byte_data;
              2'd1: word_buf_q[15:8]  <= bus.byte_data;
              2'd2: word_buf_q[23:16] <= bus.byte_data;
              default: begin
                wr_data_q <= DATA_WIDTH'({bus.byte_data, word_buf_q});
                wr_addr_q <= ADDRESS_WIDTH'({word_idx_q, 2'b00});
              end
            endcase
          end
          default: ;
        endcase
      end
      if (state_q == WRITE) word_idx_q <= word_idx_q + 16'd1;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.core_hold  = core_hold;
  assign bus.done       = done;
  assign bus.error      = error;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of whole loads plus hand-written sequences for
// start-during-WORD and reset-mid-load; memory writes checked by a scoreboard.
module tb_prog_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  prog_loader #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .MEM_SIZE     (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pulses   = 0;
  logic [31:0] last_addr = '0;
  logic [63:0] exp_q[$];          // {addr, data} of each required write
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Every cycle with wr_en high must match the next required write
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      pulses++;
      last_addr = bus.wr_addr;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL write_unexpected: got addr %0h data %0h, required no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr_data", {bus.wr_addr, bus.wr_data}, mon_exp);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_byte(input logic [7:0] b, input int stall_max);
    int n;
    int guard;
    n = (stall_max > 0) ? int'($urandom_range(stall_max, 1)) : 0;
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    guard = 0;
    while (bus.byte_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: got byte_ready low 50 cycles, required acceptance");
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int stall_max);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], stall_max);
  endtask

  // One-cycle start from IDLE/DONE/ERR; next cycle must be HDR0
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_core_hold", bus.core_hold, 1'b1);
    check("start_byte_ready", bus.byte_ready, 1'b1);
    check("start_done_error", {bus.done, bus.error}, 2'b00);
  endtask

  task automatic wait_end();
    int g;
    g = 0;
    while (!(bus.done === 1'b1 || bus.error === 1'b1) && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL end_timeout: got no done/error in 40 cycles, required one");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, bus.byte_ready, 1'b0);
    check({tag, "_wr_en"},      bus.wr_en,      1'b0);
    check({tag, "_wr_addr"},    bus.wr_addr,    32'h0);
    check({tag, "_wr_data"},    bus.wr_data,    32'h0);
    check({tag, "_done"},       bus.done,       1'b0);
    check({tag, "_error"},      bus.error,      1'b0);
    check({tag, "_core_hold"},  bus.core_hold,  1'b1);
    check({tag, "_state"},      bus.state,      3'd0);
  endtask

  // ---------------- table of loads ----------------
  typedef struct {
    int          n;
    int          stall;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_done;
    logic        exp_error;
  } load_t;

  load_t tbl[6];

  task automatic run_load(input load_t t);
    int          p0;
    logic [15:0] nn;
    logic [31:0] w;
    pulse_start();
    p0 = pulses;
    nn = 16'(t.n);
    send_byte(nn[7:0], t.stall);
    send_byte(nn[15:8], t.stall);
    if (!t.exp_error) begin
      for (int i = 0; i < t.n; i++) begin
        w = (i == 0) ? t.w0 : (i == 1) ? t.w1 : $urandom;
        exp_q.push_back({32'(i * 4), w});
        send_word(w, t.stall);
      end
    end
    wait_end();
    check("end_done",      bus.done,      t.exp_done);
    check("end_error",     bus.error,     t.exp_error);
    check("end_core_hold", bus.core_hold, !t.exp_done);
    check("write_count",   64'(pulses - p0), 64'(t.exp_error ? 0 : t.n));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    if (t.exp_done && t.n > 0)
      check("last_addr", last_addr, 32'((t.n - 1) * 4));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] w;
    load_t       one;

    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_ready", bus.byte_ready, 1'b0);
    check("idle_state",    bus.state,      3'd0);

    tbl[0] = '{n: 2,  stall: 0, w0: 32'h00100513, w1: 32'h00200593, exp_done: 1'b1, exp_error: 1'b0};
    tbl[1] = '{n: 11, stall: 0, w0: 32'h0,        w1: 32'h0,        exp_done: 1'b0, exp_error: 1'b1};
    tbl[2] = '{n: 0,  stall: 0, w0: 32'h0,        w1: 32'h0,        exp_done: 1'b1, exp_error: 1'b0};
    tbl[3] = '{n: 1,  stall: 5, w0: $urandom,     w1: 32'h0,        exp_done: 1'b1, exp_error: 1'b0};
    tbl[4] = '{n: 10, stall: 0, w0: $urandom,     w1: $urandom,     exp_done: 1'b1, exp_error: 1'b0};
    tbl[5] = '{n: 3,  stall: 2, w0: $urandom,     w1: $urandom,     exp_done: 1'b1, exp_error: 1'b0};

    for (int k = 0; k < 6; k++) run_load(tbl[k]);

    // start while assembling a word is ignored
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    w = $urandom;
    exp_q.push_back({32'h0, w});
    send_byte(w[7:0], 0);
    send_byte(w[15:8], 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("word_start_state", bus.state, 3'd3);
    send_byte(w[23:16], 0);
    send_byte(w[31:24], 0);
    wait_end();
    check("word_start_done",  bus.done, 1'b1);
    check("word_start_queue", 64'(exp_q.size()), 64'd0);

    // reset after the 2nd byte of word 1 aborts the load
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    w = $urandom | 32'h1;
    exp_q.push_back({32'h0, w});
    send_word(w, 0);
    w = $urandom;
    send_byte(w[7:0], 0);
    send_byte(w[15:8], 0);
    rst = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("after_reset_idle",  bus.state,      3'd0);
    check("after_reset_ready", bus.byte_ready, 1'b0);
    one = '{n: 1, stall: 0, w0: $urandom, w1: 32'h0, exp_done: 1'b1, exp_error: 1'b0};
    run_load(one);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, the width of the instruction-memory byte address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the width of the instruction word; the value is fixed at 4 bytes.
REQ-003 SHALL have parameter MEM_SIZE, default 10, the instruction-memory capacity in words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle request to begin a program load.
REQ-007 SHALL have port byte_valid, input, 1 bit: the source presents byte_data.
REQ-008 SHALL have port byte_data, input, 8 bits: the incoming program byte stream.
REQ-009 SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-010 SHALL have port wr_en, output, 1 bit: the instruction-memory write strobe.
REQ-011 SHALL have port wr_addr, output, ADDRESS_WIDTH bits: the byte address of the word written.
REQ-012 SHALL have port wr_data, output, DATA_WIDTH bits: the instruction word written.
REQ-013 SHALL have port core_hold, output, 1 bit: holds the processor in reset while 1.
REQ-014 SHALL have port done, output, 1 bit: the load completed successfully.
REQ-015 SHALL have port error, output, 1 bit: the header word count exceeds MEM_SIZE.

Function
REQ-016 SHALL transfer a byte only in a cycle where byte_valid and byte_ready are both 1 on the rising edge; byte_valid without byte_ready SHALL have no effect.
REQ-017 SHALL use a stream format of a 2-byte little-endian word count N, followed by N words of 4 bytes each, little-endian (first byte goes to wr_data[7:0]).
REQ-018 SHALL implement the states IDLE, HDR0, HDR1, WORD, WRITE, DONE and ERR.
REQ-019 IDLE SHALL drive byte_ready=0 and, on start=1, go to HDR0.
REQ-020 HDR0 SHALL drive byte_ready=1 and, on transfer, latch count[7:0] and go to HDR1.
REQ-021 HDR1 SHALL drive byte_ready=1 and, on transfer, latch count[15:8]; next state SHALL be DONE if N=0, ERR if N>MEM_SIZE, otherwise WORD.
REQ-022 WORD SHALL drive byte_ready=1 and place each transferred byte at lane byte_idx (0..3); byte_idx SHALL wrap 3->0 and the 4th transfer SHALL go to WRITE.
REQ-023 WRITE SHALL drive byte_ready=0 and pulse wr_en=1 for exactly one cycle, with wr_addr=word_idx*4 (zero-extended) and wr_data=the assembled word.
REQ-024 After WRITE, word_idx SHALL increment; the state SHALL go to DONE if word_idx+1=N, otherwise back to WORD.
REQ-025 The write SHALL occur in the cycle after the 4th byte's transfer edge, giving a latency of 1 cycle.
REQ-026 DONE SHALL drive done=1 and core_hold=0; start=1 SHALL clear done, set core_hold=1, reset word_idx and byte_idx to 0, and go to HDR0 (reload).
REQ-027 ERR SHALL drive error=1 and core_hold=1, perform no writes, and on start=1 clear error and go to HDR0.
REQ-028 start in HDR0, HDR1, WORD or WRITE SHALL be ignored.
REQ-029 core_hold SHALL be 1 in every state except DONE.
REQ-030 wr_en SHALL be 0 in every state except WRITE.
REQ-031 wr_addr and wr_data SHALL hold their last written values when wr_en=0.
REQ-032 A stall (byte_valid=0) SHALL stall any state indefinitely with no change to partial word contents.

Reset
REQ-033 rst=0 SHALL asynchronously force state IDLE, count=0, word_idx=0, byte_idx=0, wr_en=0, wr_addr=0, wr_data=0, byte_ready=0, done=0, error=0 and core_hold=1.
REQ-034 rst asserted mid-load SHALL abort the load immediately; memory words already written are left as written, and the next load requires start.
REQ-035 Release of rst SHALL take effect on the first rising clk after deassertion.

Verification
REQ-036 Bench SHALL check: reset then start, stream 02 00 13 05 10 00 93 05 20 00 -> wr_en pulses twice: addr 0x0 data 0x00100513, then addr 0x4 data 0x00200593; then done=1, core_hold=0.
REQ-037 Bench SHALL check: header 0B 00 with MEM_SIZE=10 -> ERR, error=1, core_hold=1, zero wr_en pulses; then start with header 00 00 -> done=1, error=0.
REQ-038 Bench SHALL check: 1-word load with byte_valid deasserted randomly for 1-5 cycles between bytes -> single write with addr 0x0 and the correct word; no byte is lost or duplicated.
REQ-039 Bench SHALL check: rst=0 pulsed after the 2nd byte of word 1 -> all outputs take their reset values immediately; a following start plus a full 1-word stream writes addr 0x0.
REQ-040 Bench SHALL check: start pulsed during WORD -> ignored; the load completes normally; start in DONE -> core_hold returns to 1 in the next cycle and a reload begins.
REQ-041 Bench SHALL check: N=10 (MEM_SIZE) -> the last write is at addr 0x24, followed by done=1.
